// File: rtl/riscv_alu.sv
// RV32I integer ALU: combinational result and zero flag, plus a registered
// copy of the result for writeback.
module riscv_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  ALU_op,
    input  logic [6:0]  ALU_op_ext,
    output logic [31:0] res,
    output logic        zero,
    output logic [31:0] res_q
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SLL  = 3'b001,
        OP_SLT  = 3'b010,
        OP_SLTU = 3'b011,
        OP_XOR  = 3'b100,
        OP_SR   = 3'b101,
        OP_OR   = 3'b110,
        OP_AND  = 3'b111
    } alu_op_e;

    logic       alt;
    logic [4:0] shamt;

    // funct7 = 0100000 selects SUB / SRA; every other value means the base op.
    assign alt   = (ALU_op_ext == 7'h20);
    assign shamt = op2[4:0];

    always_comb begin
        // NOTE: default assignment first, so no path through the case can infer a latch.
        res = '0;
        case (alu_op_e'(ALU_op))
            OP_ADD:  res = alt ? (op1 - op2) : (op1 + op2);
            OP_SLL:  res = op1 << shamt;
            OP_SLT:  res = {31'b0, $signed(op1) < $signed(op2)};
            OP_SLTU: res = {31'b0, op1 < op2};
            OP_XOR:  res = op1 ^ op2;
            OP_SR:   res = alt ? 32'($signed(op1) >>> shamt) : (op1 >> shamt);
            OP_OR:   res = op1 | op2;
            OP_AND:  res = op1 & op2;
            default: res = '0;
        endcase
    end

    assign zero = (res == '0);

    // NOTE: state registers use non-blocking assignment; comb logic above uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res;
        end
    end

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed literal cases, then randomized
// stimulus compared every cycle against a behavioural model.
module tb_riscv_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [2:0]  alu_op = '0;
    logic [6:0]  alu_op_ext = '0;
    logic [31:0] res;
    logic        zero;
    logic [31:0] res_q;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    logic [31:0] exp_q = '0;

    riscv_alu dut (
        .clk        (clk),
        .rst        (rst),
        .op1        (op1),
        .op2        (op2),
        .ALU_op     (alu_op),
        .ALU_op_ext (alu_op_ext),
        .res        (res),
        .zero       (zero),
        .res_q      (res_q)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain wide arithmetic instead of bit-level operators.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [6:0] ext);
        bit          alt = (ext == 7'h20);
        int unsigned s   = int'(b[4:0]);
        longint      ua  = longint'({32'b0, a});
        longint      ub  = longint'({32'b0, b});
        int          sa  = int'(a);
        int          sb  = int'(b);
        logic [31:0] r;
        case (op)
            3'd0: r = alt ? 32'(ua - ub) : 32'(ua + ub);
            3'd1: r = 32'(ua * (64'd1 << s));
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = 32'(ua / (64'd1 << s));
                if (alt && a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (op=%b ext=%h op1=%h op2=%h t=%0t)",
                     name, act, exp, alu_op, alu_op_ext, op1, op2, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [6:0] ext);
        op1 = a; op2 = b; alu_op = op; alu_op_ext = ext;
    endtask

    // Directed case: literal expectation for the DUT, and the same literal pins the model.
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [6:0] ext, input logic [31:0] exp);
        @(posedge clk);
        #1 drive(a, b, op, ext);
        #1;
        check(name, res, exp);
        check({name, "_zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
        check({name, "_model"}, model(a, b, op, ext), exp);
    endtask

    // Expected registered result tracks the clock edge and the async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q = '0;
        else     exp_q = model(op1, op2, alu_op, alu_op_ext);
    end

    // Per-cycle compare, sampled on the falling edge away from input changes.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("res",   res, model(op1, op2, alu_op, alu_op_ext));
            check("zero",  {31'b0, zero}, {31'b0, model(op1, op2, alu_op, alu_op_ext) == 32'd0});
            check("res_q", res_q, exp_q);
        end
    end

    initial begin
        // Reset clears res_q immediately.
        #1 rst = 1'b1;
        #1 check("rst_immediate", res_q, 32'd0);
        drive(32'd10, 32'd20, 3'b000, 7'h00);
        #1 check("res_during_rst", res, 32'd30);
        @(posedge clk);
        #1 check("rst_held_over_edge", res_q, 32'd0);
        #2 rst = 1'b0;
        #1 check("rst_release_no_edge", res_q, 32'd0);
        @(posedge clk);
        #1 check("first_edge_load", res_q, 32'd30);

        // Reset asserted between edges.
        #2 rst = 1'b1;
        #1 check("rst_mid_cycle", res_q, 32'd0);
        check("res_unaffected", res, 32'd30);
        @(posedge clk);
        #1 rst = 1'b0;

        cmp_en = 1'b1;
        directed("add",     32'd10, 32'd20, 3'b000, 7'h00, 32'd30);
        directed("sub",     32'd10, 32'd20, 3'b000, 7'h20, 32'hFFFF_FFF6);
        directed("xor",     32'd10, 32'd20, 3'b100, 7'h00, 32'd30);
        directed("or",      32'd10, 32'd20, 3'b110, 7'h00, 32'd30);
        directed("and",     32'd10, 32'd20, 3'b111, 7'h00, 32'd0);
        directed("sll",     32'd1,  32'd2,  3'b001, 7'h00, 32'd4);
        directed("sll_msk", 32'd1,  32'h22, 3'b001, 7'h20, 32'd4);
        directed("srl",     32'h8800_0000, 32'd2,  3'b101, 7'h00, 32'h2200_0000);
        directed("sra",     32'h8800_0000, 32'd2,  3'b101, 7'h20, 32'hE200_0000);
        directed("sra31",   32'h8800_0000, 32'd31, 3'b101, 7'h20, 32'hFFFF_FFFF);
        directed("srl_ext", 32'h8800_0000, 32'd2,  3'b101, 7'h01, 32'h2200_0000);
        directed("slt",     32'h8800_0000, 32'd2,  3'b010, 7'h00, 32'd1);
        directed("sltu",    32'h8800_0000, 32'd2,  3'b011, 7'h00, 32'd0);
        directed("slt_eq",  32'd2,  32'd2,  3'b010, 7'h00, 32'd0);
        directed("add_wrap", 32'h7FFF_FFFF, 32'd1, 3'b000, 7'h00, 32'h8000_0000);
        directed("sub_wrap", 32'd0, 32'd1, 3'b000, 7'h20, 32'hFFFF_FFFF);
        directed("add_ext01", 32'd10, 32'd20, 3'b000, 7'h01, 32'd30);

        // Randomized stimulus with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            logic [6:0]  e;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(0, 40));
                1:       b = a;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       e = 7'h20;
                1:       e = 7'h00;
                default: e = 7'($urandom);
            endcase
            drive(a, b, 3'($urandom), e);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_alu.md
# riscv_alu

Combinational RV32I integer ALU for the single-cycle (no-pipeline) core. It executes the ten R-type/I-type arithmetic, logic, shift and set-less-than operations selected by funct3/funct7. The primary result `res` is purely combinational and valid in the same cycle. A registered copy, `res_q`, and a zero flag are provided for writeback and branch logic.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `clk` input 1: core clock. Used only by the `res_q` register.
- `rst` input 1: asynchronous, active-high reset. Clears `res_q`.
- `op1` input 32: operand A (rs1), two's complement.
- `op2` input 32: operand B (rs2 or immediate), two's complement.
- `ALU_op` input 3: operation select, equal to instruction funct3.
- `ALU_op_ext` input 7: operation extension, equal to instruction funct7.
- `res` output 32: combinational result.
- `zero` output 1: combinational, high when `res == 0`.
- `res_q` output 32: `res` registered on the rising edge of `clk`.

## Operation
- Alternate-op qualifier `alt` is asserted only when `ALU_op_ext == 7'h20`. Any other value selects the base operation.
- Operation by `ALU_op`:
  - 3'b000: `alt` ? op1 − op2 : op1 + op2. Modulo 2^32; no overflow or carry output.
  - 3'b001 SLL: op1 << op2[4:0]. `alt` is ignored.
  - 3'b010 SLT: {31'b0, signed(op1) < signed(op2)}.
  - 3'b011 SLTU: {31'b0, unsigned(op1) < unsigned(op2)}.
  - 3'b100 XOR: op1 ^ op2.
  - 3'b101: `alt` ? op1 >>> op2[4:0] (arithmetic, sign-filled) : op1 >> op2[4:0] (logical, zero-filled).
  - 3'b110 OR: op1 | op2.
  - 3'b111 AND: op1 & op2.
- Shift amount uses only op2[4:0]; op2[31:5] is ignored.
- `alt` affects only the 000 and 101 encodings.
- `res` is a pure function of `op1`, `op2`, `ALU_op` and `ALU_op_ext`, with no internal state. No X may propagate from a defined input.
- `zero` derives from `res`, so it is valid for every operation.

## Timing
- `res` and `zero` are combinational. They settle within the same cycle, with no clock dependency, and are valid well before 1 ns after any input change in simulation.
- `res_q` captures `res` on every rising edge of `clk`. Latency is 1 cycle; there is no enable.
- `rst` high clears `res_q` to 32'h0 immediately, without waiting for a clock edge, and holds it at 0 while asserted.
- Deassertion of `rst` takes effect at the next rising edge.
- `rst` does not affect `res` or `zero`.
- Reset asserted mid-operation: `res_q` is forced to 0 at once, and the combinational outputs keep tracking the inputs.

## Test plan
- Basic ops with op1=10, op2=20:
  - ADD (000/00) -> 30
  - SUB (000/20) -> −10 (32'hFFFFFFF6)
  - XOR (100) -> 30
  - OR (110) -> 30
  - AND (111) -> 0, with `zero`=1
- SLL: op1=1, op2=2, `ALU_op`=001 -> 4. Also op2=32'h22 -> 4, confirming only op2[4:0] is used.
- Right shifts with op1=32'h88000000, op2=2:
  - SRL (101/00) -> 32'h22000000
  - SRA (101/20) -> 32'hE2000000
  - SRA by 31 -> 32'hFFFFFFFF
- Set-less-than with op1=32'h88000000, op2=2:
  - SLT -> 1
  - SLTU -> 0
  - SLT with op1=op2 -> 0
- Wrap-around: ADD 32'h7FFFFFFF + 1 -> 32'h80000000. SUB 0 − 1 -> 32'hFFFFFFFF. `ALU_op_ext`=7'h01 with 000 -> ADD.
- Register/reset:
  - Pulse `rst` -> `res_q`=0 immediately.
  - After release, the first rising edge loads the current `res` (e.g. 30) into `res_q`.
  - Asserting `rst` between edges clears `res_q` without waiting for `clk`.
